// File: rtl/sram_mem_pkg.sv
// Shared types and helpers for the banked SRAM: parameter legality checks,
// address-to-bank/row mapping and the read response tag.
package sram_mem_pkg;

  localparam int MaxPortW = 2;
  localparam int MaxBankW = 8;

  typedef struct packed {
    logic [MaxPortW-1:0] port;
    logic [MaxBankW-1:0] bank;
  } rd_tag_t;

  function automatic bit is_pow2_f(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit width_ok_f(input int w);
    return (w > 0) && ((w % 8) == 0);
  endfunction

  function automatic bit latency_ok_f(input int l);
    return (l >= 1) && (l <= 3);
  endfunction

  function automatic bit ports_ok_f(input int n);
    return (n >= 1) && (n <= 4);
  endfunction

  function automatic logic [31:0] bank_sel_f(input logic [31:0] addr, input int num_banks);
    return addr & 32'(num_banks - 1);
  endfunction

  function automatic logic [31:0] row_f(input logic [31:0] addr, input int bank_w);
    return addr >> bank_w;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One single-port bank: byte-masked write, registered read. Contents are
// deliberately not reset.
module sram_bank #(
  parameter int Width = 32,
  parameter int Depth = 1024,
  localparam int WidthBytes = Width / 8,
  localparam int RowW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [RowW-1:0]       row_i,
  input  logic [Width-1:0]      wdata_i,
  input  logic [WidthBytes-1:0] wmask_i,
  output logic [Width-1:0]      rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < WidthBytes; i++) begin
        if (wmask_i[i]) mem_q[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (en_i && !we_i) rdata_q <= mem_q[row_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_mem_banked.sv
// Multi-port word-interleaved RAM: per-bank round-robin arbitration onto
// single-port banks, with a fixed-latency per-port read response pipeline.
module sram_mem_banked
  import sram_mem_pkg::*;
#(
  parameter int Width       = 32,
  parameter int Depth       = 1 << 15,
  parameter int NumPorts    = 2,
  parameter int NumBanks    = 4,
  parameter int ReadLatency = 1,
  localparam int WidthBytes = Width / 8,
  localparam int Aw         = $clog2(Depth)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0]                  req_i,
  output logic [NumPorts-1:0]                  gnt_o,
  input  logic [NumPorts-1:0]                  write_i,
  input  logic [NumPorts-1:0][Aw-1:0]          addr_i,
  input  logic [NumPorts-1:0][Width-1:0]       wdata_i,
  input  logic [NumPorts-1:0][WidthBytes-1:0]  wmask_i,
  output logic [NumPorts-1:0]                  rvalid_o,
  output logic [NumPorts-1:0][Width-1:0]       rdata_o
);

  localparam int Bw        = $clog2(NumBanks);
  localparam int BankDepth = Depth / NumBanks;
  localparam int RowW      = (Aw > Bw) ? Aw - Bw : 1;
  localparam int BselW     = (Bw > 0) ? Bw : 1;
  localparam int PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  if (!width_ok_f(Width)) begin : g_bad_width
    $error("Width must be a positive multiple of 8");
  end
  if (!is_pow2_f(NumBanks) || !is_pow2_f(Depth) || (NumBanks > Depth)) begin : g_bad_geom
    $error("NumBanks and Depth must be powers of two with NumBanks <= Depth");
  end
  if (!latency_ok_f(ReadLatency)) begin : g_bad_lat
    $error("ReadLatency must be in 1..3");
  end
  if (!ports_ok_f(NumPorts) || (Bw > MaxBankW)) begin : g_bad_ports
    $error("NumPorts must be in 1..4 and NumBanks within tag range");
  end

  logic [NumBanks-1:0][PortW-1:0]      rr_q, rr_d;
  logic [NumPorts-1:0][BselW-1:0]      bsel;
  logic [NumPorts-1:0][RowW-1:0]       row;
  logic [NumPorts-1:0]                 gnt;
  logic [NumBanks-1:0]                 bank_en, bank_we;
  logic [NumBanks-1:0][RowW-1:0]       bank_row;
  logic [NumBanks-1:0][Width-1:0]      bank_wdata, bank_rdata;
  logic [NumBanks-1:0][WidthBytes-1:0] bank_wmask;
  int                                  arb_idx;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      bsel[p] = BselW'(bank_sel_f(32'(addr_i[p]), NumBanks));
      row[p]  = RowW'(row_f(32'(addr_i[p]), Bw));
    end
  end

  // First requester found from rr_q onward wins the bank; reset masks everything.
  always_comb begin
    gnt        = '0;
    rr_d       = rr_q;
    bank_en    = '0;
    bank_we    = '0;
    bank_row   = '0;
    bank_wdata = '0;
    bank_wmask = '0;
    arb_idx    = 0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int k = 0; k < NumPorts; k++) begin
        arb_idx = (int'(rr_q[b]) + k) % NumPorts;
        if (!bank_en[b] && req_i[arb_idx] && (bsel[arb_idx] == BselW'(b))) begin
          bank_en[b]    = 1'b1;
          bank_we[b]    = write_i[arb_idx];
          bank_row[b]   = row[arb_idx];
          bank_wdata[b] = wdata_i[arb_idx];
          bank_wmask[b] = wmask_i[arb_idx];
          gnt[arb_idx]  = 1'b1;
          rr_d[b]       = PortW'((arb_idx + 1) % NumPorts);
        end
      end
    end
    if (rst_i) begin
      gnt     = '0;
      bank_en = '0;
    end
  end

  assign gnt_o = gnt;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    sram_bank #(
      .Width (Width),
      .Depth (BankDepth)
    ) u_bank (
      .clk_i   (clk_i),
      .en_i    (bank_en[b]),
      .we_i    (bank_we[b]),
      .row_i   (bank_row[b]),
      .wdata_i (bank_wdata[b]),
      .wmask_i (bank_wmask[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  logic [NumPorts-1:0]                  rd_new;
  rd_tag_t [NumPorts-1:0]               tag_new;
  rd_tag_t                              tag_q [NumPorts][ReadLatency];
  logic [NumPorts-1:0][ReadLatency-1:0] vld_q;
  logic [NumPorts-1:0][Width-1:0]       rd_mux, rd_out;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rd_new[p]       = gnt[p] & ~write_i[p];
      tag_new[p].port = MaxPortW'(p);
      tag_new[p].bank = MaxBankW'(bsel[p]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      vld_q <= '0;
    end else begin
      rr_q <= rr_d;
      for (int p = 0; p < NumPorts; p++) begin
        vld_q[p][0] <= rd_new[p];
        for (int s = 1; s < ReadLatency; s++) vld_q[p][s] <= vld_q[p][s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      tag_q[p][0] <= tag_new[p];
      for (int s = 1; s < ReadLatency; s++) tag_q[p][s] <= tag_q[p][s-1];
    end
  end

  // Bank read registers are only valid for one cycle, so grab the data at stage 0.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rd_mux[p] = '0;
      for (int b = 0; b < NumBanks; b++) begin
        if (tag_q[p][0].bank == MaxBankW'(b)) rd_mux[p] = bank_rdata[b];
      end
    end
  end

  if (ReadLatency == 1) begin : g_nodly
    assign rd_out = rd_mux;
  end else begin : g_dly
    logic [NumPorts-1:0][Width-1:0] dat_q [ReadLatency-1];
    always_ff @(posedge clk_i) begin
      dat_q[0] <= rd_mux;
      for (int s = 1; s < ReadLatency - 1; s++) dat_q[s] <= dat_q[s-1];
    end
    assign rd_out = dat_q[ReadLatency-2];
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rvalid_o[p] = vld_q[p][ReadLatency-1] && !rst_i &&
                    (tag_q[p][ReadLatency-1].port == MaxPortW'(p));
      rdata_o[p]  = rvalid_o[p] ? rd_out[p] : '0;
    end
  end

endmodule

// File: tb/tb_sram_mem_banked.sv
// Self-checking bench for sram_mem_banked: arbitration vector table, scoreboard
// of read responses, and directed byte-mask / reset / wrap sequences.
module tb_sram_mem_banked;

  localparam int W  = 32;
  localparam int D  = 256;
  localparam int NP = 2;
  localparam int NB = 4;
  localparam int RL = 3;
  localparam int AW = 8;
  localparam int WB = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0]          req, gnt, wr, rvalid;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][W-1:0]   wdata, rdata;
  logic [NP-1:0][WB-1:0]  wmask;

  always #5 clk = ~clk;

  sram_mem_banked #(
    .Width(W), .Depth(D), .NumPorts(NP), .NumBanks(NB), .ReadLatency(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .write_i(wr),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .rvalid_o(rvalid), .rdata_o(rdata)
  );

  typedef struct { logic [W-1:0] data; int due; } sb_t;
  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [NP-1:0] exp_gnt;
    string         name;
  } vec_t;

  sb_t         q0[$], q1[$];
  sb_t         mon_e;
  logic [W-1:0] model [D];
  int          n_chk = 0, n_fail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: reads push expected data and due cycle at grant, responses pop.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      q0.delete();
      q1.delete();
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (rvalid[p]) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rvalid port %0d cycle %0d", p, cyc);
          end else begin
            if (p == 0) mon_e = q0.pop_front();
            else        mon_e = q1.pop_front();
            check("rdata", 64'(rdata[p]), 64'(mon_e.data));
            check("rlatency", 64'(cyc), 64'(mon_e.due));
          end
        end else begin
          check("rdata_idle", 64'(rdata[p]), 64'd0);
        end
      end
      check("gnt_without_req", 64'(gnt & ~req), 64'd0);
      for (int p = 0; p < NP; p++) begin
        if (req[p] && gnt[p] && !wr[p]) begin
          if (p == 0) q0.push_back('{model[addr[p]], cyc + RL});
          else        q1.push_back('{model[addr[p]], cyc + RL});
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (req[p] && gnt[p] && wr[p]) begin
          for (int i = 0; i < WB; i++)
            if (wmask[p][i]) model[addr[p]][8*i +: 8] = wdata[p][8*i +: 8];
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic acc(input int p, input logic w, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input logic [WB-1:0] m, output int gcyc);
    int n;
    n = 0;
    req[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d; wmask[p] = m;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[p] && n < 20);
    if (!gnt[p]) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_timeout port %0d addr %h", p, a);
    end
    gcyc = cyc;
    @(posedge clk);
    #1 req[p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];
  int   g0, g1, n, rv;
  logic [AW-1:0] a;

  initial begin
    tbl[0]  = '{2'b11, 2'b00, 8'd0,  8'd4,  2'b01, "conflict_0"};
    tbl[1]  = '{2'b11, 2'b00, 8'd0,  8'd4,  2'b10, "conflict_1"};
    tbl[2]  = '{2'b11, 2'b00, 8'd0,  8'd4,  2'b01, "conflict_2"};
    tbl[3]  = '{2'b11, 2'b00, 8'd0,  8'd4,  2'b10, "conflict_3"};
    tbl[4]  = '{2'b11, 2'b00, 8'd0,  8'd1,  2'b11, "parallel_banks"};
    tbl[5]  = '{2'b10, 2'b00, 8'd0,  8'd8,  2'b10, "lone_p1"};
    tbl[6]  = '{2'b01, 2'b00, 8'd2,  8'd8,  2'b01, "lone_p0_b2"};
    tbl[7]  = '{2'b11, 2'b00, 8'd6,  8'd10, 2'b10, "rr_after_p0"};
    tbl[8]  = '{2'b11, 2'b00, 8'd6,  8'd10, 2'b01, "rr_after_p1"};
    tbl[9]  = '{2'b00, 2'b00, 8'd6,  8'd10, 2'b00, "idle"};
    tbl[10] = '{2'b11, 2'b01, 8'd3,  8'd7,  2'b01, "wr_vs_rd_0"};
    tbl[11] = '{2'b11, 2'b01, 8'd3,  8'd7,  2'b10, "wr_vs_rd_1"};
    tbl[12] = '{2'b11, 2'b00, 8'd9,  8'd5,  2'b01, "rr_bank1"};

    // Reset with both ports requesting the same bank; first grant must be port 0.
    rst = 1'b1; req = 2'b11; wr = 2'b11; addr = '0;
    wdata = {32'h0, 32'h0}; wmask = {4'hF, 4'hF};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_grant", 64'(gnt), 64'(2'b01));
    @(posedge clk);
    #1 req = 2'b00;

    for (int i = 0; i < 64; i += 2) begin
      fork
        acc(0, 1'b1, AW'(i),     $urandom, 4'hF, g0);
        acc(1, 1'b1, AW'(i + 1), $urandom, 4'hF, g1);
      join
      fork
        acc(0, 1'b1, AW'(D - 64 + i), $urandom, 4'hF, g0);
        acc(1, 1'b1, AW'(D - 63 + i), $urandom, 4'hF, g1);
      join
    end

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req; wr = tbl[i].wr;
      addr[0] = tbl[i].a0; addr[1] = tbl[i].a1;
      wdata[0] = 32'hC0DE0000 | 32'(i); wdata[1] = 32'h0;
      wmask = {4'hF, 4'hF};
      @(negedge clk);
      check(tbl[i].name, 64'(gnt), 64'(tbl[i].exp_gnt));
      @(posedge clk);
      #1;
    end
    req = 2'b00;
    repeat (RL + 1) @(posedge clk);
    #1;

    acc(0, 1'b1, 8'h10, 32'hAABBCCDD, 4'hF, g0);
    acc(0, 1'b1, 8'h10, 32'h11223344, 4'b0101, g0);
    acc(0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000, g0);
    acc(0, 1'b0, 8'h10, 32'h0, 4'h0, g0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid[0] && n < 10);
    check("bytemask_latency", 64'(cyc - g0), 64'(RL));
    check("bytemask_data", 64'(rdata[0]), 64'h00000000AA22CC44);
    @(posedge clk);
    #1;

    acc(1, 1'b0, 8'd5, 32'h0, 4'h0, g1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid[1]) rv++;
    end
    check("reset_drops_read", 64'(rv), 64'd0);
    @(posedge clk);
    #1;

    acc(1, 1'b1, AW'(D - 1), 32'hDEADBEEF, 4'hF, g1);
    acc(1, 1'b0, AW'(D - 1), 32'h0, 4'h0, g1);
    for (int i = 0; i < 64; i += 2) begin
      a = AW'(D - 32 + i);
      fork
        acc(0, 1'b0, a,         32'h0, 4'h0, g0);
        acc(1, 1'b0, AW'(a + 1), 32'h0, 4'h0, g1);
      join
    end
    repeat (RL + 2) @(posedge clk);
    #1;
    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_mem_banked.md
# sram_mem_banked

Multi-port, banked, byte-maskable on-chip RAM. It replaces the single-port `sram_mem` model wherever several initiators share one backing store, e.g. instruction fetch plus load/store plus debug. `NumPorts` request channels are arbitrated round-robin, independently per bank, onto `NumBanks` word-interleaved single-port banks. Reads return after a fixed, parameterised latency.

## Interface
Parameters:
- `Width`, 32: data width in bits; multiple of 8.
- `Depth`, 1<<15: total words; power of two.
- `NumPorts`, 2: request channels, 1..4.
- `NumBanks`, 4: interleaved banks; power of two, ≤ `Depth`.
- `ReadLatency`, 1: cycles from grant to `rvalid_o`, 1..3.
- Derived: `WidthBytes`=`Width`/8; `Aw`=$clog2(`Depth`); `Bw`=$clog2(`NumBanks`); `BankDepth`=`Depth`/`NumBanks`.

Ports:
- `clk_i`  in  1  sole clock; all state on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `req_i`  in  [NumPorts]  request valid, per port.
- `gnt_o`  out  [NumPorts]  request accepted this cycle; combinational from `req_i`/`addr_i`.
- `write_i`  in  [NumPorts]  1 = write, 0 = read.
- `addr_i`  in  [NumPorts][Aw]  word address.
- `wdata_i`  in  [NumPorts][Width]  write data.
- `wmask_i`  in  [NumPorts][WidthBytes]  byte enables; bit i covers bits 8i+7:8i.
- `rvalid_o`  out  [NumPorts]  read data valid, one pulse per granted read.
- `rdata_o`  out  [NumPorts][Width]  read data; 0 when `rvalid_o` is low.

## Operation
- Bank select is `addr_i[Bw-1:0]`. Row is `addr_i[Aw-1:Bw]`.
- Each bank grants at most one port per cycle. A port is granted when it is the round-robin winner among the ports requesting that bank.
- Ports targeting different banks are all granted in the same cycle.
- Each bank has a round-robin pointer `rr_q[b]` (reset 0). Priority search order is `rr_q`, `rr_q`+1, … mod `NumPorts`.
- After a grant to port p, `rr_q[b]` becomes (p+1) mod `NumPorts`. Without a grant, `rr_q[b]` holds.
- Handshake:
  - The transfer occurs on a cycle with `req_i` & `gnt_o`.
  - The initiator holds `req_i` and its payload stable until granted.
  - `gnt_o` is never asserted without `req_i`.
- Granted write: bytes with `wmask_i`=1 are updated at the clock edge. Masked bytes keep their old value. An all-zero mask is a no-op that is still granted. Writes produce no `rvalid_o`.
- Granted read: data is captured at the edge. The data tag (port, bank) goes through a `ReadLatency`-deep valid shift register, and `rvalid_o[p]` is driven from it.
- Read-after-write: a read granted in any cycle after a write's grant returns the written data. Read and write to the same bank in one cycle cannot occur because there is one grant per bank.
- Responses on each port return in grant order. At most one `rvalid_o` per port per cycle.
- Memory contents are not reset. Reads of unwritten locations return X in simulation.

## Timing
- Reset values: `gnt_o`=0 while `rst_i`=1; `rvalid_o`=0; `rdata_o`=0; all `rr_q`=0; valid pipeline cleared.
- Read grant in cycle N gives `rvalid_o` and `rdata_o` in cycle N+`ReadLatency`.
- Throughput: one access per bank per cycle. Back-to-back reads from one port give a contiguous `rvalid_o` stream.
- Reset asserted mid-operation: in-flight reads are dropped and no `rvalid_o` follows. A write granted in the same cycle as `rst_i`=1 is not performed.
- Wrap-around: the row index uses `Aw-Bw` bits with no overflow check. Addresses are taken modulo `Depth` by width.

## Structure
- Package `sram_mem_pkg`:
  - parameter legality checks as functions;
  - `bank_sel_f` (address → bank);
  - `row_f` (address → row);
  - the response tag struct `{port, bank}`.
- Sub-module `sram_bank`:
  - one `BankDepth`×`Width` single-port array with byte-mask write and registered read;
  - instantiated `NumBanks` times.
- Top level contains the per-bank round-robin arbiters, request/response muxing, and the `ReadLatency` valid/tag pipeline.
- Elaboration assertions: `Width`%8==0; `NumBanks` and `Depth` are powers of two; `ReadLatency` is in 1..3.

## Test plan
- Reset: hold `rst_i` 3 cycles with all `req_i`=1, then release. Required: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0 during reset; the first grant goes to port 0.
- Byte mask: write 0xAABBCCDD to addr 0x10 with mask 0xF, then write 0x11223344 with mask 0b0101, then read. Required: 0xAA22CC44, exactly `ReadLatency` cycles after the read grant.
- Conflict: ports 0 and 1 read the same bank continuously. Required: grants alternate 0,1,0,1. Each port gets `rvalid_o` on alternate cycles, in order.
- Parallel banks: port 0 reads addr 0, port 1 reads addr 1 (different banks). Required: both granted the same cycle; both `rvalid_o` high together with the correct data.
- Reset mid-read: `ReadLatency`=3, grant a read, assert `rst_i` one cycle later. Required: no `rvalid_o` ever appears for that read.
- Wrap: write to `Depth`-1 and read it back. Required: correct data; no other bank or row is disturbed, checked by a full readback of a 64-word window.
